ahb_burst_master_sequencer: RTL and testbench

Master-side AHB burst engine sitting directly upstream of the AHB address/data bus that the AVIP's transfer structures describe. Accepts one burst request per handshake, drives HADDR/HTRANS/HBURST/HSIZE/HWRITE/HWDATA beat by beat with correct INCR/WRAP address arithmetic, and honours HREADY wait states and the two-cycle HRESP ERROR response. Returns read data and per-beat/burst completion status to the request side.

---
 rtl/ahb_burst_master_sequencer_if.sv | 49 ++++
 rtl/ahb_burst_master_sequencer.sv | 172 +++++++++++++++++
 tb/tb_ahb_burst_master_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_burst_master_sequencer_if.sv
// Purpose : bundles the burst-request side and the AHB master bus of the
//           burst sequencer into one interface.
// Latency : n/a (wires only).
// Backpr. : n/a; request flow uses req_valid/req_ready, AHB flow uses HREADY.
// Ports   : master modport = sequencer view, slave modport = requester + AHB
//           slave view (used by whatever drives requests and answers the bus).
interface ahb_burst_master_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  // request side
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_burst;
  logic [2:0]            req_size;
  logic                  req_write;
  logic [4:0]            req_len;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wdata_ack;
  logic                  rdata_valid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  burst_done;
  logic                  burst_err;
  // AHB side
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic [2:0]            HBURST;
  logic [2:0]            HSIZE;
  logic                  HWRITE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    input  req_valid, req_addr, req_burst, req_size, req_write, req_len, wdata,
    input  HREADY, HRESP, HRDATA,
    output req_ready, wdata_ack, rdata_valid, rdata, burst_done, burst_err,
    output HADDR, HTRANS, HBURST, HSIZE, HWRITE, HWDATA
  );

  modport slave (
    output req_valid, req_addr, req_burst, req_size, req_write, req_len, wdata,
    output HREADY, HRESP, HRDATA,
    input  req_ready, wdata_ack, rdata_valid, rdata, burst_done, burst_err,
    input  HADDR, HTRANS, HBURST, HSIZE, HWRITE, HWDATA
  );
endinterface

// File: rtl/ahb_burst_master_sequencer.sv
// Purpose : AHB master burst engine; one request in, beat-by-beat INCR/WRAP
//           address/data phases out, read data and completion status back.
// Latency : first NONSEQ the cycle after acceptance; burst_done/rdata_valid one
//           cycle after the data phase that produced them completes.
// Backpr. : req_ready only in IDLE; HREADY=0 stalls address and data phases;
//           wdata_ack tells the requester its current wdata was taken.
// Ports   : HCLK, HRESET (sync, active-high), bus (master modport).
module ahb_burst_master_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       HCLK,
  input  logic                       HRESET,
  ahb_burst_master_sequencer_if.master bus
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic [1:0]            htrans_q;
  logic [2:0]            hburst_q;
  logic [2:0]            hsize_q;
  logic                  hwrite_q;
  logic [DATA_WIDTH-1:0] hwdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rdata_valid_q;
  logic                  burst_done_q;
  logic                  burst_err_q;
  logic [4:0]            beats_left_q;  // address phases still to issue, incl. the one on the bus
  logic                  dp_vld_q;      // a data phase is in progress this cycle

  function automatic logic [4:0] burst_beats(input logic [2:0] burst, input logic [4:0] len);
    case (burst)
      3'd0:       burst_beats = 5'd1;
      3'd1:       burst_beats = (len == 5'd0) ? 5'd1 : len;
      3'd2, 3'd3: burst_beats = 5'd4;
      3'd4, 3'd5: burst_beats = 5'd8;
      default:    burst_beats = 5'd16;
    endcase
  endfunction

  // Next beat address. WRAP keeps the bits above the wrap boundary and lets
  // only the low bits roll over; even non-zero HBURST codes are the WRAP kinds.
  logic                  is_wrap;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] addr_d;

  always_comb begin
    is_wrap   = (hburst_q != 3'd0) && !hburst_q[0];
    step      = ADDR_WIDTH'(1) << hsize_q;
    wrap_mask = (ADDR_WIDTH'(burst_beats(hburst_q, 5'd0)) << hsize_q) - ADDR_WIDTH'(1);
    addr_inc  = haddr_q + step;
    addr_d    = is_wrap ? ((haddr_q & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;
  end

  logic dp_err;
  assign dp_err = dp_vld_q && bus.HRESP;

  assign bus.req_ready = (state_q == S_IDLE) && !HRESET;
  // Combinational so that back-to-back zero-wait beats can each present
  // fresh wdata; it fires exactly when the write address phase is accepted.
  assign bus.wdata_ack = (state_q == S_ADDR) && hwrite_q && bus.HREADY && !dp_err && !HRESET;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= S_IDLE;
      haddr_q       <= '0;
      htrans_q      <= TR_IDLE;
      hburst_q      <= 3'd0;
      hsize_q       <= 3'd0;
      hwrite_q      <= 1'b0;
      hwdata_q      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      burst_done_q  <= 1'b0;
      burst_err_q   <= 1'b0;
      beats_left_q  <= 5'd0;
      dp_vld_q      <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      burst_done_q  <= 1'b0;
      burst_err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            haddr_q      <= bus.req_addr;
            htrans_q     <= TR_NONSEQ;
            hburst_q     <= bus.req_burst;
            hsize_q      <= bus.req_size;
            hwrite_q     <= bus.req_write;
            beats_left_q <= burst_beats(bus.req_burst, bus.req_len);
            dp_vld_q     <= 1'b0;
            state_q      <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (dp_err) begin
            // Cancel the pending address phase; remaining beats are dropped.
            htrans_q <= TR_IDLE;
            if (bus.HREADY) begin
              state_q      <= S_IDLE;
              dp_vld_q     <= 1'b0;
              burst_done_q <= 1'b1;
              burst_err_q  <= 1'b1;
            end else begin
              state_q <= S_ERR;
            end
          end else if (bus.HREADY) begin
            if (dp_vld_q && !hwrite_q) begin
              rdata_valid_q <= 1'b1;
              rdata_q       <= bus.HRDATA;
            end
            if (hwrite_q) begin
              hwdata_q <= bus.wdata;
            end
            dp_vld_q <= 1'b1;
            if (beats_left_q == 5'd1) begin
              htrans_q <= TR_IDLE;
              state_q  <= S_LAST;
            end else begin
              haddr_q      <= addr_d;
              htrans_q     <= TR_SEQ;
              beats_left_q <= beats_left_q - 5'd1;
            end
          end
        end
        S_LAST: begin
          if (bus.HREADY) begin
            state_q      <= S_IDLE;
            dp_vld_q     <= 1'b0;
            burst_done_q <= 1'b1;
            burst_err_q  <= bus.HRESP;
            if (!bus.HRESP && !hwrite_q) begin
              rdata_valid_q <= 1'b1;
              rdata_q       <= bus.HRDATA;
            end
          end else if (bus.HRESP) begin
            state_q <= S_ERR;
          end
        end
        S_ERR: begin
          if (bus.HREADY) begin
            state_q      <= S_IDLE;
            dp_vld_q     <= 1'b0;
            burst_done_q <= 1'b1;
            burst_err_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.HADDR       = haddr_q;
  assign bus.HTRANS      = htrans_q;
  assign bus.HBURST      = hburst_q;
  assign bus.HSIZE       = hsize_q;
  assign bus.HWRITE      = hwrite_q;
  assign bus.HWDATA      = hwdata_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.burst_done  = burst_done_q;
  assign bus.burst_err   = burst_err_q;

endmodule

// File: tb/tb_ahb_burst_master_sequencer.sv
// Purpose : self-checking bench for ahb_burst_master_sequencer with a scripted
//           AHB slave (wait states, two-cycle ERROR) and expectation queues.
// Latency : n/a.
// Backpr. : slave inserts HREADY=0 cycles on a chosen beat.
module tb_ahb_burst_master_sequencer;
  localparam int AW = 32;
  localparam int DW = 32;

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  ahb_burst_master_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb_burst_master_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus.master)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [2:0]  size;
    logic        write;
  } ap_t;

  ap_t         exp_ap[$];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_wd[$];

  int errors = 0;
  int checks = 0;

  // slave / monitor state
  int   tid = 0, wd_idx = 0, ack_cnt = 0, acc_cnt = 0, done_cnt = 0, done_base = 0;
  int   stall_cnt = 0, ws_beat = -1, ws_len = 0, ws_cnt = 0, er_beat = -1, err_stage = 0;
  int   s_beat = 0, ap_beat = 0;
  logic wd_adv = 1'b0, s_dp = 1'b0, s_write = 1'b0, err_prev = 1'b0, last_err = 1'b0, active;
  logic [31:0] s_addr = '0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rpat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] wpat(input int t, input int i);
    return 32'hC0DE_0000 | (32'(t) << 8) | 32'(i);
  endfunction

  function automatic int tb_beats(input logic [2:0] b, input logic [4:0] len);
    case (b)
      3'd0:       return 1;
      3'd1:       return (len == 5'd0) ? 1 : int'(len);
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  // AHB slave model and output monitor, evaluated once per cycle mid-low phase.
  initial begin
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = '0;
    bus.wdata  = '0;
    forever begin
      @(negedge HCLK);
      if (wd_adv) begin
        wd_idx++;
        wd_adv = 1'b0;
      end
      bus.wdata = wpat(tid, wd_idx);
      if (HRESET) begin
        s_dp = 1'b0; err_stage = 0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end else if (s_dp) begin
        if (s_beat == er_beat) begin
          bus.HRESP  = 1'b1;
          bus.HREADY = (err_stage == 1);
          err_stage  = 1 - err_stage;
        end else if (s_beat == ws_beat && ws_cnt < ws_len) begin
          bus.HREADY = 1'b0; bus.HRESP = 1'b0; ws_cnt++;
        end else begin
          bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        end
        bus.HRDATA = s_write ? 32'h0 : rpat(s_addr);
      end else begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0;
      end
      #1;
      if (!HRESET) begin
        active = bus.HTRANS[1];
        if (err_prev) check("err_idle", bus.HTRANS, 2'b00);
        if (active) begin
          if (exp_ap.size() == 0) begin
            check("extra_xfer", bus.HTRANS, 2'b00);
          end else begin
            check("haddr", bus.HADDR, exp_ap[0].addr);
            check("ctrl", {bus.HTRANS, bus.HBURST, bus.HSIZE, bus.HWRITE},
                  {exp_ap[0].trans, exp_ap[0].burst, exp_ap[0].size, exp_ap[0].write});
            if (bus.HREADY) void'(exp_ap.pop_front());
          end
          if (!bus.HREADY) stall_cnt++;
        end
        if (bus.wdata_ack) begin
          ack_cnt++;
          wd_adv = 1'b1;
          check("wack_cond", {active, bus.HWRITE, bus.HREADY}, 3'b111);
        end
        if (s_dp && s_write && !bus.HRESP) begin
          if (exp_wd.size() == 0) check("wbeat_unexp", 64'(exp_wd.size()), 1);
          else if (bus.HREADY) check("hwdata", bus.HWDATA, exp_wd.pop_front());
          else check("hwdata_hold", bus.HWDATA, exp_wd[0]);
        end
        if (bus.rdata_valid) begin
          if (exp_rd.size() == 0) check("rdata_unexp", bus.rdata_valid, 1'b0);
          else check("rdata", bus.rdata, exp_rd.pop_front());
        end
        if (bus.burst_done) begin
          done_cnt++;
          last_err = bus.burst_err;
        end
        err_prev = s_dp && bus.HRESP && !bus.HREADY;
        if (s_dp && bus.HREADY) s_dp = 1'b0;
        if (active && bus.HREADY) begin
          acc_cnt++;
          s_dp    = 1'b1;
          s_write = bus.HWRITE;
          s_addr  = bus.HADDR;
          ap_beat = (bus.HTRANS == 2'b10) ? 0 : ap_beat + 1;
          s_beat  = ap_beat;
        end
      end else begin
        err_prev = 1'b0;
      end
    end
  end

  task automatic start_burst(input int t, input logic [31:0] addr, input logic [2:0] burst,
                             input logic [2:0] size, input logic wr, input logic [4:0] len,
                             input int n_ok, input int wsb, input int wsl, input int erb);
    int n;
    logic [31:0] bytes, bnd, base, a;
    logic wrap;
    tid = t; wd_idx = 0; wd_adv = 1'b0; ack_cnt = 0; stall_cnt = 0; acc_cnt = 0;
    ws_beat = wsb; ws_len = wsl; ws_cnt = 0; er_beat = erb; err_stage = 0;
    done_base = done_cnt;
    n     = tb_beats(burst, len);
    bytes = 32'd1 << size;
    bnd   = 32'(n) * bytes;
    wrap  = (burst == 3'd2) || (burst == 3'd4) || (burst == 3'd6);
    base  = (addr / bnd) * bnd;
    for (int i = 0; i < n; i++) begin
      a = wrap ? base + ((addr - base + 32'(i) * bytes) % bnd) : addr + 32'(i) * bytes;
      exp_ap.push_back('{addr: a, trans: (i == 0) ? 2'b10 : 2'b11, burst: burst, size: size, write: wr});
      if (i < n_ok) begin
        if (wr) exp_wd.push_back(wpat(t, i));
        else    exp_rd.push_back(rpat(a));
      end
    end
    @(negedge HCLK); #2;
    for (int k = 0; k < 50 && !bus.req_ready; k++) begin
      @(negedge HCLK); #2;
    end
    check("req_ready", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_burst = burst;
    bus.req_size  = size; bus.req_write = wr; bus.req_len = len;
    @(posedge HCLK); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic finish_burst(input logic exp_err, input int n_left, input int exp_acks);
    for (int k = 0; k < 300 && done_cnt == done_base; k++) begin
      @(negedge HCLK); #2;
    end
    check("burst_done", 64'(done_cnt - done_base), 1);
    check("burst_err", last_err, exp_err);
    check("ap_left", 64'(exp_ap.size()), 64'(n_left));
    check("rd_left", 64'(exp_rd.size()), 0);
    check("wd_left", 64'(exp_wd.size()), 0);
    check("wack_cnt", 64'(ack_cnt), 64'(exp_acks));
    exp_ap.delete(); exp_rd.delete(); exp_wd.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_burst = 3'd0;
    bus.req_size  = 3'd0; bus.req_write = 1'b0; bus.req_len = 5'd0;
    repeat (3) @(negedge HCLK);
    #2;
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_htrans", bus.HTRANS, 2'b00);
    check("rst_haddr", bus.HADDR, 32'h0);
    check("rst_hwdata", bus.HWDATA, 32'h0);
    check("rst_ctrl", {bus.HBURST, bus.HSIZE, bus.HWRITE}, 7'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_pulses", {bus.rdata_valid, bus.burst_done, bus.burst_err, bus.wdata_ack}, 4'h0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    check("post_rst_ready", bus.req_ready, 1'b1);

    // WRAP4 write, zero wait
    start_burst(1, 32'h38, 3'd2, 3'd2, 1'b1, 5'd0, 4, -1, 0, -1);
    finish_burst(1'b0, 0, 4);
    // INCR8 read, two wait cycles on the third beat's data phase
    start_burst(2, 32'h100, 3'd5, 3'd1, 1'b0, 5'd0, 8, 2, 2, -1);
    finish_burst(1'b0, 0, 0);
    check("stall_cnt", 64'(stall_cnt), 2);
    // INCR len 3 across 0x1000
    start_burst(3, 32'hFF8, 3'd1, 3'd2, 1'b0, 5'd3, 3, -1, 0, -1);
    finish_burst(1'b0, 0, 0);
    // INCR4 read, ERROR on second beat
    start_burst(4, 32'h40, 3'd3, 3'd2, 1'b0, 5'd0, 1, -1, 0, 1);
    finish_burst(1'b1, 2, 0);

    // WRAP8 write, reset while the fifth address phase is on the bus
    start_burst(5, 32'h28, 3'd4, 3'd2, 1'b1, 5'd0, 8, -1, 0, -1);
    for (int k = 0; k < 100 && acc_cnt < 5; k++) begin
      @(negedge HCLK); #2;
    end
    check("acc_before_rst", 64'(acc_cnt), 5);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    check("midrst_htrans", bus.HTRANS, 2'b00);
    check("midrst_haddr", bus.HADDR, 32'h0);
    check("midrst_hwdata", bus.HWDATA, 32'h0);
    check("midrst_ready", bus.req_ready, 1'b0);
    exp_ap.delete(); exp_rd.delete(); exp_wd.delete();
    @(negedge HCLK); #2;
    HRESET = 1'b0;
    repeat (3) @(negedge HCLK);
    #2;
    check("midrst_no_done", 64'(done_cnt), 64'(done_base));

    // SINGLE write after reset release
    start_burst(6, 32'h10, 3'd0, 3'd2, 1'b1, 5'd0, 1, -1, 0, -1);
    finish_burst(1'b0, 0, 1);
    // INCR with req_len 0 -> one beat
    start_burst(7, 32'h204, 3'd1, 3'd2, 1'b0, 5'd0, 1, -1, 0, -1);
    finish_burst(1'b0, 0, 0);
    // WRAP8 halfword read from an unaligned-to-boundary start, one wait state
    start_burst(8, 32'h0A, 3'd4, 3'd1, 1'b0, 5'd0, 8, 5, 1, -1);
    finish_burst(1'b0, 0, 0);
    // INCR16 write with three wait states on the first data phase
    start_burst(9, 32'h400, 3'd7, 3'd2, 1'b1, 5'd0, 16, 0, 3, -1);
    finish_burst(1'b0, 0, 16);
    check("stall_cnt16", 64'(stall_cnt), 3);

    repeat (2) @(negedge HCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
